// File: rtl/vga_timing_gen_if.sv
// Raster timing bus from vga_timing_gen to the playfield draw stages.
// The master drives every signal; draw stages attach through the slave modport.
interface vga_timing_gen_if;
    logic        pix_ce;
    logic [9:0]  counter_x;
    logic [9:0]  counter_y;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic [24:0] clks;
    logic [15:0] frame_count;

    modport master (
        output pix_ce, counter_x, counter_y, hsync, vsync, active,
               line_start, frame_start, clks, frame_count
    );

    modport slave (
        input  pix_ce, counter_x, counter_y, hsync, vsync, active,
               line_start, frame_start, clks, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate prescaler plus horizontal/vertical raster counters for 640x480@60.
// Sync, active and strobes are registered from the next counter values so they line up with x/y.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned CLKS_W   = 25;
    localparam int unsigned FC_W     = 16;
    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_nxt_c;
    logic              pix_ce_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [X_W-1:0]    x_nxt_c;
    logic [Y_W-1:0]    y_nxt_c;
    logic              x_wrap_c;
    logic              y_wrap_c;
    logic              hs_c;
    logic              vs_c;
    logic              act_c;
    logic              hsync_q;
    logic              vsync_q;
    logic              active_q;
    logic              line_start_q;
    logic              frame_start_q;
    logic [CLKS_W-1:0] clks_q;
    logic [FC_W-1:0]   fc_q;

    // Next raster position and the sync/active levels that belong to it
    always_comb begin
        div_nxt_c = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        x_wrap_c  = (x_q == X_W'(H_TOTAL - 1));
        y_wrap_c  = (y_q == Y_W'(V_TOTAL - 1));
        x_nxt_c   = x_wrap_c ? '0 : x_q + X_W'(1);
        y_nxt_c   = y_q;
        if (x_wrap_c) begin
            y_nxt_c = y_wrap_c ? '0 : y_q + Y_W'(1);
        end
        hs_c  = ((x_nxt_c >= X_W'(HS_START)) && (x_nxt_c < X_W'(HS_END))) ? HS_ON : ~HS_ON;
        vs_c  = ((y_nxt_c >= Y_W'(VS_START)) && (y_nxt_c < Y_W'(VS_END))) ? VS_ON : ~VS_ON;
        act_c = (x_nxt_c < X_W'(H_ACTIVE)) && (y_nxt_c < Y_W'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            clks_q        <= '0;
            fc_q          <= '0;
        end else begin
            clks_q        <= clks_q + CLKS_W'(1);
            div_q         <= div_nxt_c;
            // pix_ce is high in the cycle where div sits at PIX_DIV-1
            pix_ce_q      <= (div_nxt_c == DIV_W'(PIX_DIV - 1));
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (pix_ce_q) begin
                x_q           <= x_nxt_c;
                y_q           <= y_nxt_c;
                hsync_q       <= hs_c;
                vsync_q       <= vs_c;
                active_q      <= act_c;
                line_start_q  <= x_wrap_c;
                frame_start_q <= x_wrap_c && y_wrap_c;
                if (x_wrap_c && y_wrap_c) begin
                    fc_q <= fc_q + FC_W'(1);
                end
            end
        end
    end

    assign vga.pix_ce      = pix_ce_q;
    assign vga.counter_x   = x_q;
    assign vga.counter_y   = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.active      = active_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.clks        = clks_q;
    assign vga.frame_count = fc_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster source for the playfield draw stages: background, bird, pipes, score.
- Divides the system clock to a pixel rate and runs the horizontal and vertical pixel counters for 640x480@60.
- Produces hsync, vsync, the active-video flag and frame/line strobes.
- Also provides the free-running clks divider bus, which draw stages use for animation timing (for example, grass scroll).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (>=1)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  out  1  one-clk pulse per pixel period
- counter_x  out  10  horizontal position, 0..H_TOTAL-1; top level zero-extends it to the consumers' CounterX width
- counter_y  out  10  vertical position, 0..V_TOTAL-1; top level zero-extends it to the consumers' CounterY width
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- active  out  1  high when counter_x < H_ACTIVE and counter_y < V_ACTIVE
- line_start  out  1  one-clk pulse when counter_x becomes 0
- frame_start  out  1  one-clk pulse when (counter_x, counter_y) becomes (0,0)
- clks  out  25  free-running clk-cycle counter (divider bus)
- frame_count  out  16  frames completed since reset

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset is asynchronous and active-high. While reset is high:
  - div = 0, counter_x = 0, counter_y = 0, clks = 0, frame_count = 0.
  - pix_ce, active, line_start and frame_start = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL (deasserted).
- Reset deasserting mid-frame restarts timing at (0,0). There is no partial-line recovery.
- Prescaler:
  - div counts 0..PIX_DIV-1 and wraps.
  - pix_ce = 1 exactly in the clk cycle where div == PIX_DIV-1. With PIX_DIV = 1, pix_ce is held high.
- Counters advance only on a pix_ce cycle:
  - counter_x increments; at H_TOTAL-1 it wraps to 0 and counter_y increments.
  - counter_y wraps from V_TOTAL-1 to 0, only together with the counter_x wrap.
- Sync, active and strobe outputs are registered. On the pix_ce edge they are computed from the next counter values, so they stay cycle-aligned with counter_x/counter_y and add zero extra latency relative to the counters.
  - hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491. vsync changes only at the same edge as x -> 0.
  - active is as defined in Ports.
  - All of these hold their value between pix_ce cycles.
- Strobes (single clk wide):
  - line_start = 1 for the one clk in which counter_x takes the value 0.
  - frame_start = 1 for the one clk in which (x,y) takes (0,0). It coincides with a line_start.
  - Neither strobe fires on reset release. The first frame_start comes after one full frame.
- frame_count increments on frame_start and wraps 65535 -> 0.
- clks increments every clk regardless of pix_ce and wraps 2^25-1 -> 0. Consumers may clock off clks[n]; for that reason it is generated as a plain registered counter with no glitching logic.
- No input handshakes. All outputs are valid every clk once reset is released.

Test Plan:
- Reset with defaults, release at t0:
  - (x,y) stays (0,0) for 2 clks, then x=1.
  - hsync = vsync = 1, active = 0 until the first pix_ce, then active = 1.
  - clks = 1 one clk after release.
- Line timing:
  - 1600 clks between successive line_start pulses.
  - hsync low for exactly 192 clks, starting when x becomes 656.
  - active low for x in 640..799.
- Frame timing:
  - 840000 clks between frame_start pulses.
  - vsync low only for y in 490..491, i.e. 3200 clks.
  - frame_count steps 0 -> 1 -> 2 over 2 frames.
- Wrap boundaries:
  - At (799,524) the next pix_ce yields (0,0), with frame_start = line_start = 1 for one clk.
  - At (799,100) the next pix_ce yields (0,101) with line_start only.
  - Preload clks near 2^25-1 via force: it wraps to 0.
- Asynchronous reset mid-frame at (300,250), asserted between clk edges:
  - All outputs go to reset values immediately, without waiting for a clk edge.
  - After release, the first frame_start is 840000 clks later.
- Parameter override PIX_DIV=1, HS_POL=1:
  - pix_ce constantly 1.
  - 800 clks per line.
  - hsync high only for x in 656..751.
